// File: rtl/cpu_clock_ctrl_pkg.sv
// cpu_clk_defs: shared state codes and state width for the CPU clock controller
package cpu_clk_defs;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;
endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// cpu_clock_ctrl_if: divider/CPU-side signals of the clock controller
//   master: drives tick, run_sw, step_btn, halt_in; observes cpu_en, state, halted, en_count
//   slave : the controller side of the same bundle
interface cpu_clock_ctrl_if
  import cpu_clk_defs::*;
#(
  parameter int CNT_W = 16
) ();
  logic               tick;
  logic               run_sw;
  logic               step_btn;
  logic               halt_in;
  logic               cpu_en;
  logic [STATE_W-1:0] state;
  logic               halted;
  logic [CNT_W-1:0]   en_count;
  modport master (
    output tick, run_sw, step_btn, halt_in,
    input  cpu_en, state, halted, en_count
  );
  modport slave (
    input  tick, run_sw, step_btn, halt_in,
    output cpu_en, state, halted, en_count
  );
endinterface

// File: rtl/cpu_clock_ctrl_btn_debounce.sv
// btn_debounce: tick-sampled debouncer producing a level and a one-cycle rise pulse
//   clock, reset : system clock, synchronous active-high reset
//   sample_en    : sampling strobe (divider tick)
//   raw          : synchronised button value
//   level        : debounced level
//   rise         : one-cycle pulse on a debounced 0->1 change
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_en,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam logic [3:0] LIM = 4'(DEBOUNCE_TICKS);
  logic [3:0] cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sample_en) begin
        if (raw == level) cnt <= '0;
        else if (cnt == LIM - 4'd1) begin
          level <= raw;
          cnt   <= '0;
          rise  <= raw;
        end else cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: sequences the CPU clock enable in free-run, single-step and halt modes
//   clock, reset : system clock, synchronous active-high reset
//   bus          : tick/run_sw/step_btn/halt_in in; cpu_en/state/halted/en_count out
module cpu_clock_ctrl
  import cpu_clk_defs::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int CNT_W          = 16
) (
  input logic             clock,
  input logic             reset,
  cpu_clock_ctrl_if.slave bus
);
  logic             run_q, run_s, btn_q, btn_s, step_req;
  logic             en, en_nxt, halted_r;
  logic [CNT_W-1:0] cnt;
  state_t           st, nxt;
  always_ff @(posedge clock) begin
    if (reset) {run_s, run_q, btn_s, btn_q} <= '0;
    else {run_s, run_q, btn_s, btn_q} <= {run_q, bus.run_sw, btn_q, bus.step_btn};
  end
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
    .clock    (clock),
    .reset    (reset),
    .sample_en(bus.tick),
    .raw      (btn_s),
    .level    (),
    .rise     (step_req)
  );
  // halt beats a mode change, a mode change beats a pulse; the losing event is dropped
  always_comb begin
    nxt    = (st == HALT) ? HALT :
             (st == PAUSE || st == RUN) ? (bus.halt_in ? HALT : run_s ? RUN : PAUSE) : PAUSE;
    en_nxt = !bus.halt_in && ((st == RUN && run_s && bus.tick) ||
                              (st == PAUSE && !run_s && step_req));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st       <= PAUSE;
      en       <= 1'b0;
      halted_r <= 1'b0;
      cnt      <= '0;
    end else begin
      st       <= nxt;
      en       <= en_nxt;
      halted_r <= nxt == HALT;
      cnt      <= cnt + CNT_W'(en);
    end
  end
  assign bus.cpu_en   = en;
  assign bus.state    = st;
  assign bus.halted   = halted_r;
  assign bus.en_count = cnt;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: directed-plus-random bench for cpu_clock_ctrl against a rule-level model
module tb_cpu_clock_ctrl;
  localparam int DT = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  cpu_clock_ctrl_if #(.CNT_W(CW)) ifc ();
  cpu_clock_ctrl #(.DEBOUNCE_TICKS(DT), .CNT_W(CW)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (ifc)
  );
  int checks = 0, errors = 0;
  int m_rq, m_rs, m_bq, m_bs, m_lvl, m_run, m_step, m_mode, m_en, m_cnt;
  int pulses, mp, prev_cnt;
  bit arm_rst, rst_hit, saw_wrap;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask
  // mode 0 paused, 1 running, 2 halted; the model applies the mode rules as written
  task automatic model_step();
    int en_n, mode_n, step_n, lvl_n, run_n;
    if (rst) begin
      {m_rq, m_rs, m_bq, m_bs, m_lvl, m_run, m_step, m_mode, m_en, m_cnt} = '0;
    end else begin
      en_n = 0;
      mode_n = m_mode;
      if (m_mode == 2) en_n = 0;
      else if (ifc.halt_in) mode_n = 2;
      else if (m_mode == 1) begin
        if (m_rs == 0) mode_n = 0;
        else en_n = int'(ifc.tick);
      end else begin
        if (m_rs == 1) mode_n = 1;
        else en_n = m_step;
      end
      step_n = 0;
      lvl_n = m_lvl;
      run_n = m_run;
      if (ifc.tick) begin
        if (m_bs == m_lvl) run_n = 0;
        else begin
          run_n = run_n + 1;
          if (run_n == DT) begin
            lvl_n = m_bs;
            run_n = 0;
            step_n = m_bs;
          end
        end
      end
      m_cnt = (m_cnt + m_en) % (1 << CW);
      m_en = en_n;
      m_mode = mode_n;
      m_step = step_n;
      m_lvl = lvl_n;
      m_run = run_n;
      m_rs = m_rq;
      m_rq = int'(ifc.run_sw);
      m_bs = m_bq;
      m_bq = int'(ifc.step_btn);
    end
  endtask
  task automatic cycle(input logic tk);
    bit now_rst;
    now_rst = 1'b0;
    ifc.tick = tk;
    if (arm_rst && m_step == 1) begin
      rst = 1'b1;
      now_rst = 1'b1;
      rst_hit = 1'b1;
      arm_rst = 1'b0;
    end
    @(posedge clk);
    model_step();
    #1;
    chk("cpu_en", ifc.cpu_en, m_en);
    chk("state", ifc.state, m_mode);
    chk("halted", ifc.halted, m_mode == 2);
    chk("en_count", ifc.en_count, m_cnt);
    if (now_rst) begin
      chk("midrst_en", ifc.cpu_en, 0);
      chk("midrst_state", ifc.state, 0);
      chk("midrst_halted", ifc.halted, 0);
      chk("midrst_count", ifc.en_count, 0);
      rst = 1'b0;
    end
    if (ifc.cpu_en === 1'b1) pulses++;
    if (m_en == 1) mp++;
    if (prev_cnt == 15 && ifc.en_count === 4'd0) saw_wrap = 1'b1;
    prev_cnt = int'(ifc.en_count);
  endtask
  task automatic btn_tick(input logic v);
    for (int i = 0; i < 5; i++) begin
      ifc.step_btn = (i < 2) ? logic'($urandom_range(0, 1)) : v;
      cycle(i == 4);
    end
  endtask
  task automatic press();
    btn_tick(1'b1);
    btn_tick(1'b0);
    btn_tick(1'b1);
    repeat (6) btn_tick(1'b1);
    repeat (3) btn_tick(logic'($urandom_range(0, 1)));
    repeat (6) btn_tick(1'b0);
  endtask
  initial begin
    {m_rq, m_rs, m_bq, m_bs, m_lvl, m_run, m_step, m_mode, m_en, m_cnt} = '0;
    pulses = 0;
    mp = 0;
    prev_cnt = 0;
    arm_rst = 1'b0;
    rst_hit = 1'b0;
    saw_wrap = 1'b0;
    rst = 1'b1;
    ifc.tick = 1'b0;
    ifc.run_sw = 1'b0;
    ifc.step_btn = 1'b0;
    ifc.halt_in = 1'b0;
    repeat (3) cycle(1'b0);
    rst = 1'b0;
    chk("rst_state", ifc.state, 0);
    chk("rst_count", ifc.en_count, 0);
    chk("rst_en", ifc.cpu_en, 0);
    ifc.run_sw = 1'b1;
    pulses = 0;
    mp = 0;
    for (int i = 0; i < 100; i++) cycle(i % 5 == 0);
    chk("free_pulses", pulses, mp);
    chk("free_pulses_abs", pulses, 19);
    for (int i = 0; i < 60; i++) cycle($urandom_range(0, 3) == 0);
    ifc.run_sw = 1'b0;
    repeat (4) cycle(1'b0);
    pulses = 0;
    press();
    chk("step_pulses", pulses, 1);
    ifc.run_sw = 1'b1;
    repeat (4) cycle(1'b0);
    ifc.run_sw = 1'b0;
    cycle(1'b0);
    cycle(1'b0);
    pulses = 0;
    cycle(1'b1);
    repeat (3) cycle(1'b0);
    chk("coll_pulses", pulses, 0);
    chk("coll_state", ifc.state, 0);
    pulses = 0;
    press();
    chk("coll_step_pulses", pulses, 1);
    ifc.run_sw = 1'b1;
    repeat (4) cycle(1'b0);
    ifc.halt_in = 1'b1;
    pulses = 0;
    cycle(1'b1);
    ifc.halt_in = 1'b0;
    for (int i = 0; i < 20; i++) cycle(i % 5 == 0);
    press();
    chk("halt_pulses", pulses, 0);
    chk("halt_state", ifc.state, 2);
    chk("halt_flag", ifc.halted, 1);
    rst = 1'b1;
    cycle(1'b0);
    rst = 1'b0;
    pulses = 0;
    saw_wrap = 1'b0;
    for (int i = 0; i < 200 && pulses < 17; i++) cycle(i % 3 == 0);
    cycle(1'b0);
    cycle(1'b0);
    chk("wrap_pulses", pulses, 17);
    chk("wrap_count", ifc.en_count, 1);
    chk("wrap_seen", saw_wrap, 1);
    ifc.run_sw = 1'b0;
    repeat (4) cycle(1'b0);
    rst_hit = 1'b0;
    arm_rst = 1'b1;
    press();
    arm_rst = 1'b0;
    chk("midrst_hit", rst_hit, 1);
    repeat (3) cycle(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
